// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forwarding selects, hazard FSM states and
// the architectural zero register (XZR), which never carries a dependency.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LSTALL,
        FLUSH
    } hz_state_t;

    localparam logic [4:0] ZERO_REG = 5'd31;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: the datapath side (drives stage fields, consumes controls).
// slave : the hazard controller.
interface hazard_ctrl_if;
    import cpu_pkg::*;

    logic [4:0] id_Rn;
    logic [4:0] id_Rm;
    logic       id_usesRn;
    logic       id_usesRm;
    logic       id_readsFlags;
    logic [4:0] ex_Rd;
    logic       ex_RegWrite;
    logic       ex_MemToReg;
    logic       ex_flagWrite;
    logic [4:0] mem_Rd;
    logic       mem_RegWrite;
    logic [4:0] wb_Rd;
    logic       wb_RegWrite;
    logic       ex_branchTaken;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    fwd_sel_t   fwdA;
    fwd_sel_t   fwdB;

    modport master (
        output id_Rn, id_Rm, id_usesRn, id_usesRm, id_readsFlags,
        output ex_Rd, ex_RegWrite, ex_MemToReg, ex_flagWrite,
        output mem_Rd, mem_RegWrite, wb_Rd, wb_RegWrite, ex_branchTaken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwdA, fwdB
    );

    modport slave (
        input  id_Rn, id_Rm, id_usesRn, id_usesRm, id_readsFlags,
        input  ex_Rd, ex_RegWrite, ex_MemToReg, ex_flagWrite,
        input  mem_Rd, mem_RegWrite, wb_Rd, wb_RegWrite, ex_branchTaken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwdA, fwdB
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register. The younger EX/MEM
// result takes precedence over MEM/WB; writes to XZR are never forwarded.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter logic [4:0] ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output fwd_sel_t   sel
);

    // pick the newest producer of src, falling back to the register file
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd != ZERO_REG) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != ZERO_REG) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use and flag-use stalls,
// taken-branch flushes and operand forwarding selects.
// Build option: HAZARD_STATS_EN adds saturating stall/flush bubble counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter int         FLUSH_CYCLES      = 2,
    parameter logic [4:0] ZERO_REG          = cpu_pkg::ZERO_REG
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_count,
    output logic [31:0]  flush_count
`endif
);

    localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t  state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [4:0] rn_lat_reg, rm_lat_reg;
    logic       load_use, flag_use;
    logic       stall_req, flush_req;
    logic       stall_act, flush_act;

    assign load_use = bus.ex_RegWrite & bus.ex_MemToReg & (bus.ex_Rd != ZERO_REG) &
                      ((bus.id_usesRn & (bus.ex_Rd == bus.id_Rn)) |
                       (bus.id_usesRm & (bus.ex_Rd == bus.id_Rm)));
    assign flag_use = bus.id_readsFlags & bus.ex_flagWrite;

    // FSM state and remaining-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // next state and stall/flush requests; a taken branch beats any stall
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_req  = 1'b0;
        flush_req  = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.ex_branchTaken) begin
                    flush_req = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    stall_req = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_next = LSTALL;
                        cnt_next   = LOAD_RELOAD;
                    end
                end else if (flag_use) begin
                    stall_req = 1'b1;
                end
            end
            LSTALL: begin
                if (bus.ex_branchTaken) begin
                    flush_req = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_RELOAD;
                    end else begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end
                end else begin
                    stall_req = 1'b1;
                    cnt_next  = cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end
                end
            end
            FLUSH: begin
                flush_req = 1'b1;
                cnt_next  = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // controls fall back to free-running values the instant reset asserts
    always_comb begin
        stall_act       = reset & stall_req;
        flush_act       = reset & flush_req;
        bus.pc_write    = ~stall_act;
        bus.ifid_write  = ~stall_act;
        bus.ifid_flush  = flush_act;
        bus.idex_bubble = stall_act | flush_act;
    end

    // source registers of the instruction now in EX; a bubble carries XZR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rn_lat_reg <= ZERO_REG;
            rm_lat_reg <= ZERO_REG;
        end else if (bus.idex_bubble) begin
            rn_lat_reg <= ZERO_REG;
            rm_lat_reg <= ZERO_REG;
        end else begin
            rn_lat_reg <= bus.id_Rn;
            rm_lat_reg <= bus.id_Rm;
        end
    end

    logic [4:0] fwd_src [2];
    fwd_sel_t   fwd_sel [2];

    assign fwd_src[0] = rn_lat_reg;
    assign fwd_src[1] = rm_lat_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_unit #(.ZERO_REG(ZERO_REG)) u_fwd (
            .src           (fwd_src[gi]),
            .mem_rd        (bus.mem_Rd),
            .mem_reg_write (bus.mem_RegWrite),
            .wb_rd         (bus.wb_Rd),
            .wb_reg_write  (bus.wb_RegWrite),
            .sel           (fwd_sel[gi])
        );
    end

    assign bus.fwdA = fwd_sel[0];
    assign bus.fwdB = fwd_sel[1];

`ifdef HAZARD_STATS_EN
    // saturating counts of bubble cycles, split by cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall_act && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush_act && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    // without statistics the controller has no extra state
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (L=1/F=2 and L=3/F=1) share one
// stimulus stream; a per-instance reference model tracks pending bubble
// counts and EX-stage source registers. HAZARD_STATS_EN also checks counters.
module tb_hazard_ctrl;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic       uses_rn, uses_rm, reads_flags;
    logic       ex_rw, ex_m2r, ex_fw, mem_rw, wb_rw, br;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    hazard_ctrl_if bus [2] ();
    logic [7:0]  obs [2];
    logic [31:0] st_cnt [2];
    logic [31:0] fl_cnt [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign bus[gi].id_Rn          = id_rn;
        assign bus[gi].id_Rm          = id_rm;
        assign bus[gi].id_usesRn      = uses_rn;
        assign bus[gi].id_usesRm      = uses_rm;
        assign bus[gi].id_readsFlags  = reads_flags;
        assign bus[gi].ex_Rd          = ex_rd;
        assign bus[gi].ex_RegWrite    = ex_rw;
        assign bus[gi].ex_MemToReg    = ex_m2r;
        assign bus[gi].ex_flagWrite   = ex_fw;
        assign bus[gi].mem_Rd         = mem_rd;
        assign bus[gi].mem_RegWrite   = mem_rw;
        assign bus[gi].wb_Rd          = wb_rd;
        assign bus[gi].wb_RegWrite    = wb_rw;
        assign bus[gi].ex_branchTaken = br;
        assign obs[gi] = {bus[gi].pc_write, bus[gi].ifid_write, bus[gi].ifid_flush,
                          bus[gi].idex_bubble, bus[gi].fwdA, bus[gi].fwdB};

        hazard_ctrl #(
            .LOAD_STALL_CYCLES (gi == 0 ? 1 : 3),
            .FLUSH_CYCLES      (gi == 0 ? 2 : 1)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .bus         (bus[gi])
`ifdef HAZARD_STATS_EN
            ,
            .stall_count (st_cnt[gi]),
            .flush_count (fl_cnt[gi])
`endif
        );
`ifndef HAZARD_STATS_EN
        assign st_cnt[gi] = 32'd0;
        assign fl_cnt[gi] = 32'd0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          stall_left [2];
    int          flush_left [2];
    logic [4:0]  lat_rn [2];
    logic [4:0]  lat_rm [2];
    int unsigned m_stall [2];
    int unsigned m_flush [2];

    function automatic int lcyc(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int fcyc(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic bit m_load_use();
        return ex_rw && ex_m2r && (ex_rd != 5'd31) &&
               ((uses_rn && ex_rd == id_rn) || (uses_rm && ex_rd == id_rm));
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] r);
        if (mem_rw && mem_rd != 5'd31 && mem_rd == r) return 2'b01;
        if (wb_rw && wb_rd != 5'd31 && wb_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            stall_left[i] = 0;
            flush_left[i] = 0;
            lat_rn[i]     = 5'd31;
            lat_rm[i]     = 5'd31;
            m_stall[i]    = 0;
            m_flush[i]    = 0;
        end
    endtask

    // expected outputs this cycle, then advance the model by one clock
    task automatic model_cycle(input int i, output logic [7:0] expv);
        bit st, fl;
        st = 0;
        fl = 0;
        if (reset) begin
            if (flush_left[i] > 0) fl = 1;
            else if (stall_left[i] > 0) begin
                if (br) fl = 1; else st = 1;
            end else if (br) fl = 1;
            else if (m_load_use() || (reads_flags && ex_fw)) st = 1;
        end
        expv = {~st, ~st, fl, st | fl, m_fwd(lat_rn[i]), m_fwd(lat_rm[i])};
        if (reset) begin
            if (flush_left[i] > 0) flush_left[i]--;
            else if (stall_left[i] > 0) begin
                if (br) begin
                    stall_left[i] = 0;
                    flush_left[i] = fcyc(i) - 1;
                end else stall_left[i]--;
            end else if (br) flush_left[i] = fcyc(i) - 1;
            else if (m_load_use()) stall_left[i] = lcyc(i) - 1;
            lat_rn[i] = (st | fl) ? 5'd31 : id_rn;
            lat_rm[i] = (st | fl) ? 5'd31 : id_rm;
            if (st) m_stall[i]++;
            if (fl) m_flush[i]++;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        chk_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    // one clock: compare at negedge against the model, then drive after posedge
    task automatic step();
        logic [7:0] e [2];
        @(negedge clk);
        if (!reset) model_clear();
        for (int i = 0; i < 2; i++) begin
`ifdef HAZARD_STATS_EN
            check_eq($sformatf("stall_cnt%0d c%0d", i, cyc), st_cnt[i], m_stall[i]);
            check_eq($sformatf("flush_cnt%0d c%0d", i, cyc), fl_cnt[i], m_flush[i]);
`endif
            model_cycle(i, e[i]);
            check_eq($sformatf("ctl%0d c%0d", i, cyc), {24'd0, obs[i]}, {24'd0, e[i]});
        end
        $display("cyc=%0d rst=%0b br=%0b lu=%0b obs0=%02h exp0=%02h obs1=%02h exp1=%02h",
                 cyc, reset, br, m_load_use(), obs[0], e[0], obs[1], e[1]);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rn = 5'd31; id_rm = 5'd31; uses_rn = 0; uses_rm = 0; reads_flags = 0;
        ex_rd = 5'd31; ex_rw = 0; ex_m2r = 0; ex_fw = 0;
        mem_rd = 5'd31; mem_rw = 0; wb_rd = 5'd31; wb_rw = 0; br = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_rw = 1; ex_m2r = 1; ex_rd = rd; id_rn = 5'd5; uses_rn = 1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd5;
            1: return 5'd7;
            2: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        idle();
        model_clear();
        reset = 1'b0;
        #3;
        check_eq("reset_ctl0", {24'd0, obs[0]}, 32'hC0);
        check_eq("reset_ctl1", {24'd0, obs[1]}, 32'hC0);
        step();
        reset = 1'b1;
        step();

        // load-use on X5: one bubble for L=1, three for L=3
        set_load(5'd5);
        #3 check_eq("ldur_stall", {26'd0, obs[0][7:2]}, 32'b000100);
        step();
        idle();
        #3 check_eq("ldur_run", {26'd0, obs[0][7:2]}, 32'b110000);
        check_eq("ldur_l3_hold", {26'd0, obs[1][7:2]}, 32'b000100);
        repeat (3) step();

        // same stimulus on XZR: no stall
        set_load(5'd31);
        #3 check_eq("xzr_nostall", {26'd0, obs[0][7:2]}, 32'b110000);
        step();
        idle();

        // taken branch: flush held two cycles with PC still advancing
        br = 1;
        #3 check_eq("br_flush0", {26'd0, obs[0][7:2]}, 32'b111100);
        step();
        br = 0;
        #3 check_eq("br_flush1", {26'd0, obs[0][7:2]}, 32'b111100);
        step();
        #3 check_eq("br_done", {26'd0, obs[0][7:2]}, 32'b110000);
        step();

        // branch and load-use together: flush wins
        set_load(5'd5);
        br = 1;
        #3 check_eq("br_vs_load", {26'd0, obs[0][7:2]}, 32'b111100);
        step();
        idle();
        repeat (2) step();

        // forwarding on operand A from X7, operand B on XZR
        id_rn = 5'd7; id_rm = 5'd31;
        step();
        mem_rd = 5'd7; mem_rw = 1; wb_rd = 5'd7; wb_rw = 1;
        #3 check_eq("fwdA_mem", {30'd0, obs[0][3:2]}, 32'b01);
        step();
        mem_rw = 0;
        #3 check_eq("fwdA_wb", {30'd0, obs[0][3:2]}, 32'b10);
        check_eq("fwdB_xzr", {30'd0, obs[0][1:0]}, 32'b00);
        step();
        idle();
        step();

        // B.cond behind a flag setter: single-cycle stall
        reads_flags = 1; ex_fw = 1;
        #3 check_eq("flag_stall", {26'd0, obs[0][7:2]}, 32'b000100);
        step();
        idle();
        #3 check_eq("flag_done", {26'd0, obs[0][7:2]}, 32'b110000);
        step();

        // asynchronous reset in the middle of a 3-cycle load stall
        set_load(5'd5);
        step();
        #2 reset = 1'b0;
        #1 check_eq("rst_mid_lstall", {24'd0, obs[1]}, 32'hC0);
        step();
        reset = 1'b1;
        idle();
        #3 check_eq("rst_release_run", {26'd0, obs[1][7:2]}, 32'b110000);
        step();

        // three load stalls then one branch
        for (int k = 0; k < 3; k++) begin
            set_load(5'd5);
            step();
            idle();
            repeat (3) step();
        end
        br = 1;
        step();
        br = 0;
        repeat (3) step();
`ifdef HAZARD_STATS_EN
        #3 check_eq("stats_stall", st_cnt[0], 32'd3);
        check_eq("stats_flush", fl_cnt[0], 32'd2);
`endif

        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 300; n++) begin
            id_rn = pick_reg(); id_rm = pick_reg();
            uses_rn = 1'($urandom); uses_rm = 1'($urandom);
            reads_flags = ($urandom_range(0, 3) == 0);
            ex_rd = pick_reg(); ex_rw = 1'($urandom); ex_m2r = 1'($urandom);
            ex_fw = 1'($urandom);
            mem_rd = pick_reg(); mem_rw = 1'($urandom);
            wb_rd = pick_reg(); wb_rw = 1'($urandom);
            br = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) != 0);
            step();
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
